nbody_pair_sched: RTL and testbench
===================================

Name: nbody_pair_sched

Overview:
- Sequencer for the n-body force pipeline.
- After a GO, runs GAP timesteps. Each timestep has two phases:
  - Force phase: issues every ordered body pair (i,j), i≠j, into the fixed-latency force pipeline, one pair per accepted cycle.
  - Update phase: issues one position/velocity update per body.
- Sits between the register-interface decode (GO, N_BODIES, GAP, DONE) and the force/update datapath. Owns all pair-index and step counting.

Parameters:
- BODY_ADDR_WIDTH, 9, width of a body index (max 512 bodies).
- STEP_WIDTH, 16, width of the GAP/step counters.
- INFLIGHT_WIDTH, 8, width of the in-flight counter; must hold the pipeline latency (122).
- UPD_LATENCY, 12, cycles from the last update issue until its write-back completes.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- go  in  1  single-cycle start pulse.
- n_bodies  in  BODY_ADDR_WIDTH+1  body count; sampled on an accepted go.
- gap  in  STEP_WIDTH  timesteps per run; sampled on an accepted go; 0 is treated as 1.
- issue_valid  out  1  pair valid toward the force pipeline.
- issue_ready  in  1  pipeline/memory accepts the pair this cycle.
- issue_i  out  BODY_ADDR_WIDTH  target body index.
- issue_j  out  BODY_ADDR_WIDTH  source body index.
- issue_first  out  1  first j for this i (clears the accumulator).
- issue_last  out  1  last j for this i (commits the accumulator).
- ret_valid  in  1  one result leaving the pipeline tail.
- upd_valid  out  1  update strobe for body upd_idx.
- upd_idx  out  BODY_ADDR_WIDTH  body being updated.
- busy  out  1  high in every state except IDLE and DONE.
- done  out  1  level; high in DONE until the next accepted go.
- step_count  out  STEP_WIDTH  completed timesteps in the current run.
- err  out  1  sticky; set when ret_valid arrives with in-flight == 0; cleared only by reset or an accepted go.

Behaviour:
- Reset values: state=IDLE; every output 0; internal counters 0.
- States: IDLE, FORCE, DRAIN, UPDATE, UWAIT, DONE.
- go handling:
  - go is accepted only in IDLE or DONE; it is ignored in every other state.
  - On accept: latch n_bodies and gap, clear step_count and err, set i=0, j=first valid j.
  - Next state is FORCE if n≥2, UPDATE if n==1, DONE if n==0. The n==0 case enters DONE on the cycle after go and issues nothing.
- FORCE:
  - issue_valid=1 with the current (i,j).
  - Order: i outer 0..n-1; j inner 0..n-1, skipping j==i.
  - issue_first is high when j is the lowest valid j for this i (j=0, or j=1 when i=0).
  - issue_last is high when j is the highest valid j for this i (n-1, or n-2 when i=n-1).
  - The pair advances only when issue_valid && issue_ready. While ready is low, all issue_* outputs hold stable.
  - Pairs per step: n(n-1).
  - After the handshake on pair (n-1,n-2), go to DRAIN; issue_valid=0 from the next cycle.
- In-flight counter:
  - +1 on an issue handshake; -1 on ret_valid; unchanged when both occur in the same cycle.
  - ret_valid at 0: counter stays 0 and err is set.
- DRAIN: when the counter reads 0, move to UPDATE on the next cycle.
- UPDATE:
  - upd_valid=1 for exactly n consecutive cycles, upd_idx=0..n-1. No backpressure.
  - Then go to UWAIT.
- UWAIT:
  - Wait UPD_LATENCY cycles, then step_count += 1.
  - If step_count (after the increment) == effective gap → DONE; otherwise → FORCE, restarting at i=0.
- Steps are serialized: no pair of step k+1 issues before every update of step k has retired.
- Asynchronous reset mid-run returns everything to reset values immediately. Results still in the datapath are ignored by the scheduler, because counters are cleared.
- Index counters never wrap: n ≤ 2^BODY_ADDR_WIDTH. n_bodies greater than 512 is clamped to 512.

Test Plan:
- Basic run: n=3, gap=1, issue_ready=1, ret_valid = issue handshake delayed 122 cycles → pairs in order (0,1),(0,2),(1,0),(1,2),(2,0),(2,1) on 6 consecutive cycles. issue_first is high on (0,1),(1,0),(2,0); issue_last is high on (0,2),(1,2),(2,1). Then upd_idx 0,1,2, then done=1, step_count=1, err=0.
- Backpressure: n=3, issue_ready low on the cycle presenting (0,2) → (0,2) is held for that cycle and the next. Total handshakes still 6. No pair is skipped or duplicated.
- Multiple steps: n=25, gap=2 → 600 handshakes per step, 1200 total. The second step's first issue comes only after UWAIT of step 1. Final step_count=2, done=1.
- Degenerate counts:
  - n=1, gap=1 → zero issue_valid cycles, one upd_valid with upd_idx=0, then done.
  - n=0 → done=1 on the cycle after go, with no issue or update activity.
- Robustness:
  - go pulsed during FORCE is ignored (sequence unchanged).
  - ret_valid injected while in-flight==0 sets err=1; the next accepted go clears it.
  - rst asserted mid-FORCE → busy=0, issue_valid=0, done=0 immediately, state IDLE.

Source files
------------

// File: rtl/nbody_pair_sched_if.sv
// rtl/nbody_pair_sched_if.sv - force/update datapath handshake bundle for the n-body pair scheduler
// Ports (as seen from the scheduler through modport master):
//    issue_valid/issue_ready  pair handshake toward the force pipeline
//    issue_i, issue_j         target / source body index of the pair
//    issue_first, issue_last  accumulator clear / commit markers for the current target
//    ret_valid                one result leaving the force pipeline tail
//    upd_valid, upd_idx       position/velocity update strobe and body index
`timescale 1ns/1ps
interface nbody_pair_sched_if #(
   parameter int BODY_ADDR_WIDTH = 9
);
   logic                       issue_valid;
   logic                       issue_ready;
   logic [BODY_ADDR_WIDTH-1:0] issue_i;
   logic [BODY_ADDR_WIDTH-1:0] issue_j;
   logic                       issue_first;
   logic                       issue_last;
   logic                       ret_valid;
   logic                       upd_valid;
   logic [BODY_ADDR_WIDTH-1:0] upd_idx;

   modport master (
      output issue_valid, issue_i, issue_j, issue_first, issue_last, upd_valid, upd_idx,
      input  issue_ready, ret_valid
   );

   modport slave (
      input  issue_valid, issue_i, issue_j, issue_first, issue_last, upd_valid, upd_idx,
      output issue_ready, ret_valid
   );
endinterface

// File: rtl/nbody_pair_sched.sv
// rtl/nbody_pair_sched.sv - timestep sequencer issuing ordered body pairs and per-body updates
// Ports:
//    clk, rst          clock, asynchronous active-low reset
//    go                start pulse, accepted only in IDLE or DONE
//    n_bodies, gap     body count (clamped to 2^BODY_ADDR_WIDTH) and timestep count (0 runs one step)
//    dp                datapath bundle (modport master): pair issue, pipeline return, update strobe
//    busy, done        run in progress / run finished (level until the next accepted go)
//    step_count        completed timesteps of the current run
//    err               sticky: a return arrived while nothing was in flight
`timescale 1ns/1ps
module nbody_pair_sched #(
   parameter int BODY_ADDR_WIDTH = 9,
   parameter int STEP_WIDTH      = 16,
   parameter int INFLIGHT_WIDTH  = 8,
   parameter int UPD_LATENCY     = 12
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     go,
   input  logic [BODY_ADDR_WIDTH:0] n_bodies,
   input  logic [STEP_WIDTH-1:0]    gap,
   nbody_pair_sched_if.master       dp,
   output logic                     busy,
   output logic                     done,
   output logic [STEP_WIDTH-1:0]    step_count,
   output logic                     err
);
   localparam int BA     = BODY_ADDR_WIDTH;
   localparam int NW     = BODY_ADDR_WIDTH + 1;
   localparam int WAIT_W = $clog2(UPD_LATENCY + 1);
   localparam logic [NW-1:0] N_MAX = {1'b1, {BODY_ADDR_WIDTH{1'b0}}};

   typedef enum logic [2:0] {IDLE, FORCE, DRAIN, UPDATE, UWAIT, DONE} state_t;

   state_t                    state_q, state_d;
   logic [NW-1:0]             n_q, n_d;
   logic [STEP_WIDTH-1:0]     gap_q, gap_d;
   logic [BA-1:0]             i_q, i_d;
   logic [BA-1:0]             j_q, j_d;
   logic [BA-1:0]             upd_q, upd_d;
   logic [STEP_WIDTH-1:0]     step_q, step_d;
   logic [INFLIGHT_WIDTH-1:0] infl_q, infl_d;
   logic [WAIT_W-1:0]         wait_q, wait_d;
   logic                      err_q, err_d;

   logic [NW-1:0] n_eff, n_m1, n_m2, last_j;
   logic [BA-1:0] first_j;
   logic          hs;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         n_q     <= '0;
         gap_q   <= '0;
         i_q     <= '0;
         j_q     <= '0;
         upd_q   <= '0;
         step_q  <= '0;
         infl_q  <= '0;
         wait_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         n_q     <= n_d;
         gap_q   <= gap_d;
         i_q     <= i_d;
         j_q     <= j_d;
         upd_q   <= upd_d;
         step_q  <= step_d;
         infl_q  <= infl_d;
         wait_q  <= wait_d;
         err_q   <= err_d;
      end
   end

   assign n_eff   = (n_bodies > N_MAX) ? N_MAX : n_bodies;
   assign n_m1    = n_q - NW'(1);
   assign n_m2    = n_q - NW'(2);
   // The last target body has no j == n-1 partner once j == i is skipped.
   assign last_j  = ({1'b0, i_q} == n_m1) ? n_m2 : n_m1;
   assign first_j = (i_q == '0) ? BA'(1) : '0;
   assign hs      = (state_q == FORCE) && dp.issue_ready;

   always_comb begin
      state_d = state_q;
      n_d     = n_q;
      gap_d   = gap_q;
      i_d     = i_q;
      j_d     = j_q;
      upd_d   = upd_q;
      step_d  = step_q;
      infl_d  = infl_q;
      wait_d  = wait_q;
      err_d   = err_q;

      case (state_q)
         IDLE, DONE: begin
            if (go) begin
               n_d    = n_eff;
               gap_d  = (gap == '0) ? STEP_WIDTH'(1) : gap;
               step_d = '0;
               err_d  = 1'b0;
               i_d    = '0;
               j_d    = BA'(1);
               upd_d  = '0;
               if (n_eff >= NW'(2))      state_d = FORCE;
               else if (n_eff == NW'(1)) state_d = UPDATE;
               else                      state_d = DONE;
            end
         end
         FORCE: begin
            if (hs) begin
               if ({1'b0, j_q} == last_j) begin
                  if ({1'b0, i_q} == n_m1) begin
                     state_d = DRAIN;
                  end else begin
                     i_d = i_q + BA'(1);
                     j_d = '0;
                  end
               end else begin
                  // j is below last_j here, so stepping over i always lands on a valid j.
                  j_d = ((j_q + BA'(1)) == i_q) ? j_q + BA'(2) : j_q + BA'(1);
               end
            end
         end
         DRAIN: begin
            if (infl_q == '0) begin
               state_d = UPDATE;
               upd_d   = '0;
            end
         end
         UPDATE: begin
            if ({1'b0, upd_q} == n_m1) begin
               state_d = UWAIT;
               wait_d  = '0;
            end else begin
               upd_d = upd_q + BA'(1);
            end
         end
         UWAIT: begin
            if (wait_q == WAIT_W'(UPD_LATENCY - 1)) begin
               step_d = step_q + STEP_WIDTH'(1);
               if ((step_q + STEP_WIDTH'(1)) == gap_q) begin
                  state_d = DONE;
               end else begin
                  i_d     = '0;
                  j_d     = BA'(1);
                  upd_d   = '0;
                  state_d = (n_q >= NW'(2)) ? FORCE : UPDATE;
               end
            end else begin
               wait_d = wait_q + WAIT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      // Simultaneous issue and return cancel; a return with nothing in flight is an error.
      case ({hs, dp.ret_valid})
         2'b10:   infl_d = infl_q + INFLIGHT_WIDTH'(1);
         2'b01: begin
            if (infl_q == '0) err_d  = 1'b1;
            else              infl_d = infl_q - INFLIGHT_WIDTH'(1);
         end
         default: ;
      endcase
   end

   assign dp.issue_valid = (state_q == FORCE);
   assign dp.issue_i     = i_q;
   assign dp.issue_j     = j_q;
   assign dp.issue_first = (state_q == FORCE) && (j_q == first_j);
   assign dp.issue_last  = (state_q == FORCE) && ({1'b0, j_q} == last_j);
   assign dp.upd_valid   = (state_q == UPDATE);
   assign dp.upd_idx     = upd_q;
   assign busy           = (state_q != IDLE) && (state_q != DONE);
   assign done           = (state_q == DONE);
   assign step_count     = step_q;
   assign err            = err_q;
endmodule

// File: tb/tb_nbody_pair_sched.sv
// tb/tb_nbody_pair_sched.sv - scoreboard bench for nbody_pair_sched with a 122-cycle return pipeline model
`timescale 1ns/1ps
module tb_nbody_pair_sched;
   localparam int BA      = 9;
   localparam int SW      = 16;
   localparam int LAT     = 122;
   localparam int UPD_LAT = 12;

   typedef struct {
      bit is_upd;
      int i;
      int j;
      bit first;
      bit last;
   } ev_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          go;
   logic [BA:0]   n_bodies;
   logic [SW-1:0] gap;
   logic          busy, done, err;
   logic [SW-1:0] step_count;
   logic          ret_out;
   logic          ret_inject;
   logic [LAT-1:0] pipe;

   ev_t exp_q[$];
   ev_t mon_e;
   int  checks = 0;
   int  failures = 0;
   int  cyc = 0;
   int  hs_count = 0;
   int  hs_base = 0;
   int  last_upd_cyc = 0;
   bit  after_upd = 0;
   bit  hold = 0;
   logic [BA-1:0] hold_i, hold_j;
   logic          hold_f, hold_l;

   nbody_pair_sched_if #(.BODY_ADDR_WIDTH(BA)) bus ();
   assign bus.ret_valid = ret_out | ret_inject;

   nbody_pair_sched #(
      .BODY_ADDR_WIDTH(BA), .STEP_WIDTH(SW), .INFLIGHT_WIDTH(8), .UPD_LATENCY(UPD_LAT)
   ) dut (
      .clk(clk), .rst(rst_n), .go(go), .n_bodies(n_bodies), .gap(gap),
      .dp(bus.master), .busy(busy), .done(done), .step_count(step_count), .err(err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Monitor: pops the scoreboard on every issue handshake and update strobe, models the pipeline tail.
   always @(negedge clk) begin
      cyc++;
      if (!rst_n) begin
         pipe    = '0;
         ret_out = 1'b0;
         hold    = 0;
         exp_q.delete();
      end else begin
         if (go) after_upd = 0;
         if (hold) begin
            check("hold_valid", int'(bus.issue_valid), 1);
            check("hold_i", int'(bus.issue_i), int'(hold_i));
            check("hold_j", int'(bus.issue_j), int'(hold_j));
            check("hold_first", int'(bus.issue_first), int'(hold_f));
            check("hold_last", int'(bus.issue_last), int'(hold_l));
         end
         if (bus.issue_valid && bus.issue_ready) begin
            hs_count++;
            if (after_upd) begin
               check("uwait_gap", cyc - last_upd_cyc, UPD_LAT + 1);
               after_upd = 0;
            end
            if (exp_q.size() == 0) begin
               check("unexpected_issue", 1, 0);
            end else begin
               mon_e = exp_q.pop_front();
               check("kind_issue", int'(mon_e.is_upd), 0);
               check("pair_i", int'(bus.issue_i), mon_e.i);
               check("pair_j", int'(bus.issue_j), mon_e.j);
               check("pair_first", int'(bus.issue_first), int'(mon_e.first));
               check("pair_last", int'(bus.issue_last), int'(mon_e.last));
            end
         end
         if (bus.upd_valid) begin
            if (exp_q.size() == 0) begin
               check("unexpected_upd", 1, 0);
            end else begin
               mon_e = exp_q.pop_front();
               check("kind_upd", int'(mon_e.is_upd), 1);
               check("upd_idx", int'(bus.upd_idx), mon_e.i);
            end
            last_upd_cyc = cyc;
            after_upd    = 1;
         end
         hold   = bus.issue_valid && !bus.issue_ready;
         hold_i = bus.issue_i;
         hold_j = bus.issue_j;
         hold_f = bus.issue_first;
         hold_l = bus.issue_last;
         ret_out = pipe[LAT-1];
         pipe    = {pipe[LAT-2:0], bus.issue_valid && bus.issue_ready};
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_pair(input int i, input int j, input bit f, input bit l);
      ev_t e;
      e.is_upd = 0; e.i = i; e.j = j; e.first = f; e.last = l;
      exp_q.push_back(e);
   endtask

   task automatic push_upd(input int k);
      ev_t e;
      e.is_upd = 1; e.i = k; e.j = 0; e.first = 0; e.last = 0;
      exp_q.push_back(e);
   endtask

   task automatic push_n3();
      push_pair(0, 1, 1, 0);
      push_pair(0, 2, 0, 1);
      push_pair(1, 0, 1, 0);
      push_pair(1, 2, 0, 1);
      push_pair(2, 0, 1, 0);
      push_pair(2, 1, 0, 1);
      push_upd(0);
      push_upd(1);
      push_upd(2);
   endtask

   task automatic push_step(input int n);
      for (int i = 0; i < n; i++)
         for (int j = 0; j < n; j++)
            if (j != i)
               push_pair(i, j, j == ((i == 0) ? 1 : 0), j == ((i == n - 1) ? n - 2 : n - 1));
      for (int k = 0; k < n; k++) push_upd(k);
   endtask

   task automatic start(input int n, input int g);
      tick();
      n_bodies = (BA+1)'(n);
      gap      = SW'(g);
      go       = 1'b1;
      tick();
      go      = 1'b0;
      hs_base = hs_count;
   endtask

   task automatic wait_done(input string name, input int budget);
      int k = 0;
      while (!done && k < budget) begin
         tick();
         k++;
      end
      check({name, "_done"}, int'(done), 1);
   endtask

   task automatic finish_run(input string name, input int steps, input int pairs);
      check({name, "_step_count"}, int'(step_count), steps);
      check({name, "_err"}, int'(err), 0);
      check({name, "_busy"}, int'(busy), 0);
      check({name, "_queue_left"}, exp_q.size(), 0);
      check({name, "_handshakes"}, hs_count - hs_base, pairs);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b1; go = 1'b0; n_bodies = '0; gap = '0; ret_inject = 1'b0;
      bus.issue_ready = 1'b1;
      #2 rst_n = 1'b0;
      tick();
      tick();
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_err", int'(err), 0);
      check("rst_step", int'(step_count), 0);
      check("rst_issue_valid", int'(bus.issue_valid), 0);
      check("rst_upd_valid", int'(bus.upd_valid), 0);
      rst_n = 1'b1;

      // Basic n=3 single step
      push_n3();
      start(3, 1);
      check("basic_busy", int'(busy), 1);
      wait_done("basic", 2000);
      finish_run("basic", 1, 6);

      // Backpressure on (0,2) and a go during FORCE that must be ignored
      push_n3();
      start(3, 1);
      tick();
      check("bp_present_j", int'(bus.issue_j), 2);
      bus.issue_ready = 1'b0;
      tick();
      check("bp_held_valid", int'(bus.issue_valid), 1);
      check("bp_held_j", int'(bus.issue_j), 2);
      bus.issue_ready = 1'b1;
      n_bodies = 10'd7;
      gap = 16'd9;
      go = 1'b1;
      tick();
      go = 1'b0;
      wait_done("bp", 2000);
      finish_run("bp", 1, 6);

      // Two steps of 25 bodies
      push_step(25);
      push_step(25);
      start(25, 2);
      wait_done("multi", 6000);
      finish_run("multi", 2, 1200);

      // Single body, gap 0 treated as one step
      push_upd(0);
      start(1, 0);
      wait_done("n1", 500);
      finish_run("n1", 1, 0);

      // Reset in the middle of FORCE
      push_step(25);
      start(25, 1);
      repeat (50) tick();
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_busy", int'(busy), 0);
      check("mid_rst_issue_valid", int'(bus.issue_valid), 0);
      check("mid_rst_done", int'(done), 0);
      check("mid_rst_step", int'(step_count), 0);
      tick();
      rst_n = 1'b1;
      tick();

      // Zero bodies: DONE on the cycle after go
      check("n0_pre_done", int'(done), 0);
      start(0, 5);
      check("n0_done_next", int'(done), 1);
      finish_run("n0", 0, 0);

      // Return with nothing in flight, cleared by the next accepted go
      tick();
      ret_inject = 1'b1;
      tick();
      ret_inject = 1'b0;
      check("err_set", int'(err), 1);
      tick();
      check("err_sticky", int'(err), 1);
      start(0, 1);
      check("err_cleared", int'(err), 0);
      check("err_run_done", int'(done), 1);

      tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
